// File: rtl/aes128_encrypt.sv
// Iterative AES-128 encryptor: one round per clock, round key expanded on the fly.
// Optional debug port round_idx is enabled by defining AES_ROUND_OBS_EN.
module aes128_encrypt (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic         done
`ifdef AES_ROUND_OBS_EN
    ,
    output logic [3:0]   round_idx
`endif
);

    // Forward S-box, byte 0x00 in the top byte of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {ST_IDLE, ST_RUN} fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [127:0] state_reg, state_next;
    logic [127:0] rkey_reg, rkey_next;
    logic [127:0] ct_reg, ct_next;
    logic [3:0]   round_reg, round_next;
    logic         done_reg, done_next;

    logic [127:0] sub_bytes, shift_rows, mix_cols, next_key;
    logic [31:0]  key_t;

    // Entry for byte b sits (255-b) bytes up from bit 0, and 255-b == ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Byte i lives at bits [127-8i -: 8]; column i/4, row i%4.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            localparam int COL = gi / 4;
            localparam int ROW = gi % 4;
            localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
            assign sub_bytes[127-8*gi -: 8]  = sbox(state_reg[127-8*gi -: 8]);
            assign shift_rows[127-8*gi -: 8] = sub_bytes[127-8*SRC -: 8];
        end

        for (gi = 0; gi < 4; gi++) begin : g_cols
            logic [7:0] a0, a1, a2, a3;
            assign a0 = shift_rows[127-32*gi -: 8];
            assign a1 = shift_rows[119-32*gi -: 8];
            assign a2 = shift_rows[111-32*gi -: 8];
            assign a3 = shift_rows[103-32*gi -: 8];
            // 3*x is xtime(x)^x
            assign mix_cols[127-32*gi -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end

        for (gi = 0; gi < 4; gi++) begin : g_words
            if (gi == 0) begin : g_first
                assign next_key[127:96] = rkey_reg[127:96] ^ key_t;
            end else begin : g_chain
                assign next_key[127-32*gi -: 32] = rkey_reg[127-32*gi -: 32] ^ next_key[159-32*gi -: 32];
            end
        end
    endgenerate

    // SubWord(RotWord(w3)) XOR Rcon for the round about to execute.
    assign key_t = {sbox(rkey_reg[23:16]), sbox(rkey_reg[15:8]),
                    sbox(rkey_reg[7:0]),   sbox(rkey_reg[31:24])}
                   ^ {rcon(round_reg), 24'h000000};

    // Next-state logic: load on start, then one round per clock until round 10.
    always_comb begin
        fsm_next   = fsm_reg;
        state_next = state_reg;
        rkey_next  = rkey_reg;
        ct_next    = ct_reg;
        round_next = round_reg;
        done_next  = 1'b0;
        case (fsm_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = plaintext ^ key;
                    rkey_next  = key;
                    round_next = 4'd1;
                    fsm_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                rkey_next = next_key;
                if (round_reg == 4'd10) begin
                    state_next = shift_rows ^ next_key;
                    ct_next    = shift_rows ^ next_key;
                    done_next  = 1'b1;
                    round_next = 4'd0;
                    fsm_next   = ST_IDLE;
                end else begin
                    state_next = mix_cols ^ next_key;
                    round_next = round_reg + 4'd1;
                end
            end
            default: fsm_next = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_reg   <= ST_IDLE;
            state_reg <= '0;
            rkey_reg  <= '0;
            ct_reg    <= '0;
            round_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            fsm_reg   <= fsm_next;
            state_reg <= state_next;
            rkey_reg  <= rkey_next;
            ct_reg    <= ct_next;
            round_reg <= round_next;
            done_reg  <= done_next;
        end
    end

    assign ciphertext = ct_reg;
    assign busy       = (fsm_reg == ST_RUN);
    assign done       = done_reg;
`ifdef AES_ROUND_OBS_EN
    assign round_idx  = round_reg;
`endif

endmodule

// File: tb/tb_aes128_encrypt.sv
// Directed-vector bench for aes128_encrypt (FIPS-197 vectors, handshake corner cases).
module tb_aes128_encrypt;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         busy;
    logic         done;
`ifdef AES_ROUND_OBS_EN
    logic [3:0]   round_idx;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_encrypt dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .ciphertext (ciphertext),
        .busy       (busy),
        .done       (done)
`ifdef AES_ROUND_OBS_EN
        ,
        .round_idx  (round_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_round(input string tag, input logic [3:0] exp);
`ifdef AES_ROUND_OBS_EN
        checks++;
        assert (round_idx === exp) else begin
            errors++;
            $error("FAIL %s round_idx observed=%0d expected=%0d", tag, round_idx, exp);
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge E0 with the given inputs; start dropped right after.
    task automatic launch(input string tag, input logic [127:0] pt, input logic [127:0] k);
        plaintext = pt;
        key       = k;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check_bit({tag, " busy_e0"}, busy, 1'b1);
        check_round({tag, " e0"}, 4'd1);
    endtask

    // Edges E1..E10 after a launch: busy through E9, done exactly at E10.
    task automatic finish_block(input string tag, input logic [127:0] exp, input logic [127:0] prev_ct);
        for (int e = 1; e <= 9; e++) begin
            tick();
            check_bit($sformatf("%s busy_e%0d", tag, e), busy, 1'b1);
            check_bit($sformatf("%s done_e%0d", tag, e), done, 1'b0);
            check_round($sformatf("%s e%0d", tag, e), 4'(e + 1));
        end
        check_vec({tag, " ct_hold"}, ciphertext, prev_ct);
        tick();
        check_bit({tag, " done_e10"}, done, 1'b1);
        check_bit({tag, " busy_e10"}, busy, 1'b0);
        check_vec({tag, " ct"}, ciphertext, exp);
        check_round({tag, " e10"}, 4'd0);
        $display("block %s ciphertext=%h", tag, ciphertext);
    endtask

    task automatic after_done(input string tag, input logic [127:0] exp);
        tick();
        check_bit({tag, " done_pulse"}, done, 1'b0);
        check_vec({tag, " ct_held"}, ciphertext, exp);
    endtask

    int done_seen;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        plaintext = '0;
        key       = '0;

        // Power-up reset held for several cycles
        repeat (4) tick();
        check_vec("reset ct", ciphertext, 128'h0);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset done", done, 1'b0);
        check_round("reset", 4'd0);
        rst_n = 1'b1;
        tick();
        check_bit("idle busy", busy, 1'b0);

        // FIPS-197 App. B
        launch("appB", PT_B, K_B);
        finish_block("appB", CT_B, 128'h0);
        after_done("appB", CT_B);

        // FIPS-197 App. C.1
        launch("appC1", PT_C, K_C);
        finish_block("appC1", CT_C, CT_B);
        after_done("appC1", CT_C);

        // All-zero plaintext and key
        launch("zero", 128'h0, 128'h0);
        finish_block("zero", CT_Z, CT_C);
        after_done("zero", CT_Z);

        // Start while busy is ignored; inputs change after E0
        launch("stab", PT_B, K_B);
        tick();
        plaintext = PT_C;
        key       = K_C;
        start     = 1'b1;
        tick();
        tick();
        start     = 1'b0;
        check_bit("stab busy_mid", busy, 1'b1);
        repeat (6) tick();
        check_bit("stab done_e9", done, 1'b0);
        tick();
        check_bit("stab done_e10", done, 1'b1);
        check_vec("stab ct", ciphertext, CT_B);
        $display("block stab ciphertext=%h", ciphertext);

        // Start in the done cycle: back-to-back block
        launch("b2b", PT_C, K_C);
        finish_block("b2b", CT_C, CT_B);
        after_done("b2b", CT_C);

        // Reset at edge E5 aborts the block
        launch("abort", PT_B, K_B);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_bit("abort busy", busy, 1'b0);
        check_bit("abort done", done, 1'b0);
        check_vec("abort ct", ciphertext, 128'h0);
        check_round("abort", 4'd0);
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check_vec("abort no_done", 128'(done_seen), 128'h0);
        $display("block abort done_seen=%0d", done_seen);

        // Full encryption after the aborted block
        launch("post", 128'h0, 128'h0);
        finish_block("post", CT_Z, 128'h0);
        after_done("post", CT_Z);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
